// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types, PC-select state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } pcsel_state_t;

    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_ctrl_if.sv
// ============================================================================
// Module      : next_pc_ctrl_if
// Description : PC control bundle between the program counter / hazard /
//               branch logic (master) and the next-PC controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface next_pc_ctrl_if;
    import cpu_types_pkg::*;

    word_t npc;
    word_t PC;
    logic  ihit;
    logic  hz_stall;
    logic  br_taken;
    word_t br_target;
    logic  jmp_valid;
    word_t jmp_target;
    logic  halt;

    word_t newpc;
    logic  pcEN;
    logic  flush_ifid;
    logic  flush_idex;
    logic  pending;
    logic  halted;

    modport master (
        output npc, PC, ihit, hz_stall, br_taken, br_target,
               jmp_valid, jmp_target, halt,
        input  newpc, pcEN, flush_ifid, flush_idex, pending, halted
    );

    modport slave (
        input  npc, PC, ihit, hz_stall, br_taken, br_target,
               jmp_valid, jmp_target, halt,
        output newpc, pcEN, flush_ifid, flush_idex, pending, halted
    );

endinterface

`default_nettype wire

// File: rtl/next_pc_ctrl.sv
// ============================================================================
// Module      : next_pc_ctrl
// Description : Next-PC select: sequential fetch, branch/jump redirect with
//               hold-over across fetch stalls, pipeline flush pulses and halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    next_pc_ctrl_if.slave      bus
);

    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_PEND   = PEND;
    localparam logic [1:0] ST_HALTED = HALTED;

    logic [1:0] r_state;
    word_t      r_pend_tgt;
    logic       r_pend_is_br;

    logic [1:0] w_state_nxt;
    word_t      w_pend_tgt_nxt;
    logic       w_pend_is_br_nxt;

    word_t      w_br_tgt;
    word_t      w_red_tgt;
    logic       w_red_valid;

    word_t      w_newpc;
    logic       w_pcen;
    logic       w_flush_ifid;
    logic       w_flush_idex;
    logic       w_pending;
    logic       w_halted;

    // Redirect select: the older MEM-stage branch wins over the ID-stage jump.
    always_comb begin
        w_br_tgt    = word_align(bus.br_target);
        w_red_valid = bus.br_taken | bus.jmp_valid;
        w_red_tgt   = bus.br_taken ? w_br_tgt : word_align(bus.jmp_target);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pend_tgt_nxt   = r_pend_tgt;
        w_pend_is_br_nxt = r_pend_is_br;
        w_newpc          = bus.npc;
        w_pcen           = 1'b0;
        w_flush_ifid     = 1'b0;
        w_flush_idex     = 1'b0;
        w_pending        = 1'b0;
        w_halted         = 1'b0;

        if (RST) begin
            w_newpc = PC_RESET;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (w_red_valid) begin
                        w_flush_ifid = 1'b1;
                        w_flush_idex = bus.br_taken;
                        if (bus.ihit && !bus.hz_stall) begin
                            w_pcen  = 1'b1;
                            w_newpc = w_red_tgt;
                        end else begin
                            w_state_nxt      = ST_PEND;
                            w_pend_tgt_nxt   = w_red_tgt;
                            w_pend_is_br_nxt = bus.br_taken;
                        end
                    end else begin
                        w_pcen = bus.ihit & ~bus.hz_stall;
                    end
                end

                // The instruction behind a held redirect is wrong-path, so its
                // stall and any younger jump or branch are ignored.
                ST_PEND: begin
                    w_pending = 1'b1;
                    if (bus.halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (bus.br_taken && !r_pend_is_br) begin
                        w_flush_ifid     = 1'b1;
                        w_flush_idex     = 1'b1;
                        w_pend_tgt_nxt   = w_br_tgt;
                        w_pend_is_br_nxt = 1'b1;
                        if (bus.ihit) begin
                            w_pcen      = 1'b1;
                            w_newpc     = w_br_tgt;
                            w_state_nxt = ST_RUN;
                        end
                    end else if (bus.ihit) begin
                        w_pcen      = 1'b1;
                        w_newpc     = r_pend_tgt;
                        w_state_nxt = ST_RUN;
                    end
                end

                ST_HALTED: begin
                    w_halted = 1'b1;
                    w_newpc  = bus.PC;
                end

                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_RUN;
            r_pend_tgt   <= '0;
            r_pend_is_br <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_tgt   <= w_pend_tgt_nxt;
            r_pend_is_br <= w_pend_is_br_nxt;
        end
    end

    assign bus.newpc      = w_newpc;
    assign bus.pcEN       = w_pcen;
    assign bus.flush_ifid = w_flush_ifid;
    assign bus.flush_idex = w_flush_idex;
    assign bus.pending    = w_pending;
    assign bus.halted     = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_next_pc_ctrl.sv
// ============================================================================
// Module      : tb_next_pc_ctrl
// Description : Scoreboard bench for next_pc_ctrl: directed scenarios followed
//               by random traffic, checked against a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_next_pc_ctrl;
    import cpu_types_pkg::*;

    localparam word_t C_PC_RESET = 32'h0000_0000;
    localparam int    C_RAND_CYCLES = 800;

    typedef struct {
        int    cyc;
        word_t newpc;
        logic  pcen;
        logic  fi;
        logic  fe;
        logic  pend;
        logic  halted;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    next_pc_ctrl_if bus();

    next_pc_ctrl #(.PC_RESET(C_PC_RESET)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   stim_done = 1'b0;

    // Behavioural model: a fetch unit that is either running, holding one
    // redirect target (remembering whether it came from a branch) or halted.
    bit    m_halted  = 1'b0;
    bit    m_holding = 1'b0;
    bit    m_hold_br = 1'b0;
    word_t m_hold_pc = '0;

    function automatic exp_t model_step();
        exp_t  e;
        word_t bt, jt;
        e.cyc = cyc; e.newpc = bus.npc; e.pcen = 0; e.fi = 0; e.fe = 0;
        e.pend = 0; e.halted = 0;
        bt = {bus.br_target[31:2], 2'b00};
        jt = {bus.jmp_target[31:2], 2'b00};
        if (rst) begin
            e.newpc = C_PC_RESET;
            m_halted = 0; m_holding = 0; m_hold_br = 0;
        end else if (m_halted) begin
            e.halted = 1; e.newpc = bus.PC;
        end else if (m_holding) begin
            e.pend = 1;
            if (bus.halt) begin
                m_halted = 1; m_holding = 0;
            end else if (bus.br_taken && !m_hold_br) begin
                e.fi = 1; e.fe = 1;
                m_hold_pc = bt; m_hold_br = 1;
                if (bus.ihit) begin
                    e.pcen = 1; e.newpc = bt; m_holding = 0;
                end
            end else if (bus.ihit) begin
                e.pcen = 1; e.newpc = m_hold_pc; m_holding = 0;
            end
        end else if (bus.halt) begin
            m_halted = 1;
        end else if (bus.br_taken || bus.jmp_valid) begin
            e.fi = 1; e.fe = bus.br_taken;
            if (bus.ihit && !bus.hz_stall) begin
                e.pcen = 1; e.newpc = bus.br_taken ? bt : jt;
            end else begin
                m_holding = 1; m_hold_br = bus.br_taken;
                m_hold_pc = bus.br_taken ? bt : jt;
            end
        end else begin
            e.pcen = bus.ihit && !bus.hz_stall;
        end
        return e;
    endfunction

    // One cycle of stimulus: inputs change on the falling edge, expectation
    // is queued once they have settled.
    task automatic cyc_drive(input bit r, input bit ih, input bit hz,
                             input bit br, input word_t bt,
                             input bit jv, input word_t jt,
                             input bit hl, input word_t np);
        @(negedge clk);
        rst            = r;
        bus.ihit       = ih;
        bus.hz_stall   = hz;
        bus.br_taken   = br;
        bus.br_target  = bt;
        bus.jmp_valid  = jv;
        bus.jmp_target = jt;
        bus.halt       = hl;
        bus.npc        = np;
        bus.PC         = np - 32'd4;
        #1;
        exp_q.push_back(model_step());
        cyc++;
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.newpc !== e.newpc || bus.pcEN !== e.pcen ||
                    bus.flush_ifid !== e.fi || bus.flush_idex !== e.fe ||
                    bus.pending !== e.pend || bus.halted !== e.halted) begin
                    errors++;
                    $display("FAIL cyc%0d outputs: got newpc=%h pcEN=%b fi=%b fe=%b pend=%b halted=%b, expected newpc=%h pcEN=%b fi=%b fe=%b pend=%b halted=%b",
                             e.cyc, bus.newpc, bus.pcEN, bus.flush_ifid,
                             bus.flush_idex, bus.pending, bus.halted,
                             e.newpc, e.pcen, e.fi, e.fe, e.pend, e.halted);
                end
            end
        end
    end

    initial begin
        word_t np;
        bus.ihit = 0; bus.hz_stall = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.jmp_valid = 0; bus.jmp_target = '0; bus.halt = 0;
        bus.npc = '0; bus.PC = '0;

        // Reset then sequential fetch
        cyc_drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        cyc_drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        cyc_drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h4);
        cyc_drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h8);
        // Branch with hit
        cyc_drive(0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h8);
        cyc_drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h104);
        // Misaligned jump during a miss, held three cycles
        cyc_drive(0, 0, 0, 0, 0, 1, 32'h203, 0, 32'h108);
        for (int i = 0; i < 3; i++) cyc_drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h108);
        cyc_drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h108);
        // Older branch overrides a held jump; later jump ignored
        cyc_drive(0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h204);
        cyc_drive(0, 0, 0, 1, 32'h300, 0, 0, 0, 32'h204);
        cyc_drive(0, 0, 0, 0, 0, 1, 32'h400, 0, 32'h204);
        cyc_drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h204);
        // Halt together with a branch, then ten ignored cycles
        cyc_drive(0, 1, 0, 1, 32'h500, 0, 0, 1, 32'h304);
        for (int i = 0; i < 10; i++)
            cyc_drive(0, 1, 0, i[0], 32'h600, 0, 0, 0, 32'h400 + 32'(i) * 4);
        // Stall, branch under stall, reset while holding it
        cyc_drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        cyc_drive(0, 1, 1, 0, 0, 0, 0, 0, 32'h4);
        cyc_drive(0, 1, 1, 1, 32'h700, 0, 0, 0, 32'h4);
        cyc_drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h8);
        cyc_drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h8);

        // Random traffic
        for (int i = 0; i < C_RAND_CYCLES; i++) begin
            np = {$urandom()} & WORD_ALIGN_MASK;
            cyc_drive($urandom_range(0, 39) == 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0, $urandom(),
                      $urandom_range(0, 5) == 0, $urandom(),
                      $urandom_range(0, 59) == 0, np);
        end
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (!stim_done) begin
            errors++;
            $display("FAIL timeout: stimulus ran %0d cycles, limit 5000", guard);
        end
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/next_pc_ctrl.md
Name: next_pc_ctrl

Overview:
- Drives the program counter's control inputs: produces newpc and pcEN every cycle from the PC+4 value (npc), branch/jump redirects, cache hit, hazard stall and halt.
- Holds a redirect that arrives while fetch is stalled until it can be applied.
- Issues pipeline-flush pulses.
- Sits between the program counter and the hazard/branch logic in the pipelined datapath.

Parameters:
PC_RESET, 32'h0000_0000, value driven on newpc during reset and reported by the bench as the first fetch address.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
npc  in  32  PC+4 from the program counter
PC  in  32  current PC from the program counter (used only for the halted hold value)
ihit  in  1  instruction fetch completes this cycle
hz_stall  in  1  hazard-unit stall (load-use); blocks PC advance
br_taken  in  1  MEM-stage branch resolved taken
br_target  in  32  branch target
jmp_valid  in  1  ID-stage J/JAL/JR
jmp_target  in  32  jump target
halt  in  1  HALT reached MEM stage
newpc  out  32  next PC value to the program counter
pcEN  out  1  program counter load enable
flush_ifid  out  1  clear IF/ID latch (1-cycle pulse)
flush_idex  out  1  clear ID/EX latch (1-cycle pulse)
pending  out  1  a redirect is held, waiting for ihit
halted  out  1  in HALTED state

Behaviour:
- Registered state:
  - FSM {RUN, PEND, HALTED}.
  - pend_tgt[31:0].
  - pend_is_br (1 bit).
- All outputs are combinational from the registered state and the current inputs. Zero-cycle latency to the program counter.
- Reset: while RST=1:
  - State ← RUN, pend_tgt ← 0, pend_is_br ← 0.
  - Outputs: pcEN=0, newpc=PC_RESET, all flushes 0, pending=0, halted=0.
- Targets: bits [1:0] are forced to 00 before use or capture.
- Redirect select (this cycle): br_taken has priority over jmp_valid; red_tgt is the selected target.
- RUN:
  - halt=1 → HALTED. pcEN=0, no flush; any redirect in the same cycle is ignored.
  - Else, redirect present and ihit=1 and hz_stall=0 → pcEN=1, newpc=red_tgt, stay in RUN.
  - Else, redirect present (ihit=0 or hz_stall=1) → capture pend_tgt/pend_is_br, go to PEND, pcEN=0.
  - Else, no redirect: pcEN = ihit & ~hz_stall, newpc = npc.
  - Flushes (in the cycle the redirect is first seen, whether applied or captured):
    - branch → flush_ifid=1 and flush_idex=1.
    - jump → flush_ifid=1 only.
- PEND:
  - pending=1. hz_stall is ignored, because the stalled instruction is wrong-path.
  - halt=1 → HALTED.
  - Else, br_taken=1 with pend_is_br=0 → overwrite pend_tgt (the older branch overrides the younger jump), set pend_is_br, pulse both flushes.
    - If ihit=1 in that cycle, apply the new target immediately: pcEN=1, newpc=br_target.
  - Else, ihit=1 → pcEN=1, newpc=pend_tgt, go to RUN.
  - Any other request while pending (jump, or branch behind a pending branch) is wrong-path: ignore it, no flush.
- HALTED:
  - pcEN=0, newpc=PC, halted=1. All inputs are ignored.
  - Exit only by RST.
- RST asserted mid-PEND discards the pending target. The next state is RUN.

Decomposition:
- cpu_types_pkg: word_t is reused. Add these to it:
  - pcsel_state_t enum {RUN, PEND, HALTED}.
  - Localparam WORD_ALIGN_MASK = 32'hFFFF_FFFC.
- No sub-module. The redirect-select mux is a small always_comb inside the block.
- Pairs with program_counter_if.pc: this block drives newpc and pcEN, and consumes npc and PC.

Test Plan:
- Reset, then sequential fetch: RST=1 for 2 cycles → newpc=0, pcEN=0. Release with ihit=1, npc=4 → pcEN=1, newpc=4. Drop ihit → pcEN=0.
- Branch with hit: br_taken=1, br_target=32'h100, ihit=1 → pcEN=1, newpc=0x100, flush_ifid=flush_idex=1 for 1 cycle, pending=0.
- Jump during miss:
  - jmp_valid=1, jmp_target=32'h203 (misaligned), ihit=0 → pending=1, flush_ifid=1, flush_idex=0.
  - Hold ihit=0 for 3 cycles → pcEN=0.
  - Then ihit=1 → newpc=0x200, pcEN=1, pending=0.
- Priority in PEND:
  - Pending jump to 0x200. br_taken=1, br_target=0x300 arrives with ihit=0 → both flushes pulse, pend_tgt=0x300.
  - A later jmp_valid is ignored, no flush.
  - ihit=1 → newpc=0x300.
- Simultaneous halt and branch: halt=1, br_taken=1, ihit=1 → halted=1, pcEN=0, no flush. Stays halted for 10 cycles with ihit=1 and npc changing; newpc=PC.
- Stall interaction, then reset mid-PEND:
  - hz_stall=1, ihit=1, no redirect → pcEN=0.
  - br_taken with hz_stall=1 → PEND.
  - Assert RST → next cycle pending=0, newpc=PC_RESET.
  - Release RST with ihit=1 → newpc=npc (the old target is gone).
